multi_bank_buffer: RTL and testbench

- N-bank generalisation of the ping-pong buffer: NUM_BANKS banks in one ram_sync_1r1w.
- Explicit producer/consumer handshakes: commit a filled bank, release a drained bank.
- Tracks full/free bank occupancy, so the producer may run up to NUM_BANKS banks ahead of the consumer.
- Sits between a feature producer (e.g. MFCC/conv stage) and a consumer that reads each bank randomly.

---
 rtl/multi_bank_buffer_if.sv | 31 +++
 rtl/multi_bank_buffer.sv | 166 ++++++++++++++++
 tb/tb_multi_bank_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/multi_bank_buffer_if.sv
// Producer/consumer bus for multi_bank_buffer: write port, commit/release
// handshakes, read port and occupancy status.
interface multi_bank_buffer_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 7,
    parameter int BANK_SEL_WIDTH  = 2
);
    logic                       wen;
    logic [BANK_ADDR_WIDTH-1:0] wadr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       wr_commit;
    logic                       wr_ready;
    logic                       ren;
    logic [BANK_ADDR_WIDTH-1:0] radr;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       rdata_valid;
    logic                       rd_release;
    logic                       rd_valid;
    logic [BANK_SEL_WIDTH:0]    full_count;
    logic                       err;

    modport master (
        output wen, wadr, wdata, wr_commit, ren, radr, rd_release,
        input  wr_ready, rdata, rdata_valid, rd_valid, full_count, err
    );

    modport slave (
        input  wen, wadr, wdata, wr_commit, ren, radr, rd_release,
        output wr_ready, rdata, rdata_valid, rd_valid, full_count, err
    );
endinterface

// File: rtl/multi_bank_buffer.sv
// NUM_BANKS-deep bank buffer over a single 1R1W SRAM: the producer fills and
// commits banks, the consumer reads them randomly and releases them in order.
module ram_sync_1r1w #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] wadr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] radr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_r [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage array and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_r[wadr] <= wdata;
        end
        if (ren) begin
            rdata_r <= mem_r[radr];
        end
    end

    assign rdata = rdata_r;
endmodule

module multi_bank_buffer #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 7,
    parameter int NUM_BANKS       = 4,
    parameter int BANK_SEL_WIDTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_bank_buffer_if.slave  bus
);
    localparam int RAM_ADDR_WIDTH = BANK_SEL_WIDTH + BANK_ADDR_WIDTH;
    localparam logic [BANK_SEL_WIDTH:0]   FULL_LEVEL = (BANK_SEL_WIDTH+1)'(NUM_BANKS);
    localparam logic [BANK_SEL_WIDTH:0]   CNT_ONE    = (BANK_SEL_WIDTH+1)'(1'b1);
    localparam logic [BANK_SEL_WIDTH:0]   CNT_ZERO   = (BANK_SEL_WIDTH+1)'(1'b0);
    localparam logic [BANK_SEL_WIDTH-1:0] PTR_ONE    = BANK_SEL_WIDTH'(1'b1);
    localparam logic [BANK_SEL_WIDTH-1:0] PTR_ZERO   = BANK_SEL_WIDTH'(1'b0);

    logic [BANK_SEL_WIDTH-1:0] wr_ptr_r;
    logic [BANK_SEL_WIDTH-1:0] rd_ptr_r;
    logic [BANK_SEL_WIDTH:0]   full_count_r;
    logic                      rdata_valid_r;
    logic                      err_r;

    logic [BANK_SEL_WIDTH-1:0] wr_ptr_nxt_s;
    logic [BANK_SEL_WIDTH-1:0] rd_ptr_nxt_s;
    logic [BANK_SEL_WIDTH:0]   full_count_nxt_s;
    logic                      err_nxt_s;

    logic                      wr_ready_s;
    logic                      rd_valid_s;
    logic                      write_acc_s;
    logic                      commit_acc_s;
    logic                      read_acc_s;
    logic                      release_acc_s;
    logic                      proto_err_s;

    logic [RAM_ADDR_WIDTH-1:0] ram_wadr_s;
    logic [RAM_ADDR_WIDTH-1:0] ram_radr_s;
    logic [DATA_WIDTH-1:0]     ram_rdata_s;

    // Acceptance is judged only on registered occupancy, never on same-cycle requests.
    always_comb begin
        wr_ready_s    = 1'b0;
        rd_valid_s    = 1'b0;
        write_acc_s   = 1'b0;
        commit_acc_s  = 1'b0;
        read_acc_s    = 1'b0;
        release_acc_s = 1'b0;
        proto_err_s   = 1'b0;
        if (full_count_r < FULL_LEVEL) begin
            wr_ready_s = 1'b1;
        end else begin
            wr_ready_s = 1'b0;
        end
        if (full_count_r != CNT_ZERO) begin
            rd_valid_s = 1'b1;
        end else begin
            rd_valid_s = 1'b0;
        end
        write_acc_s   = bus.wen        & wr_ready_s;
        commit_acc_s  = bus.wr_commit  & wr_ready_s;
        read_acc_s    = bus.ren        & rd_valid_s;
        release_acc_s = bus.rd_release & rd_valid_s;
        proto_err_s   = ((bus.wen | bus.wr_commit) & ~wr_ready_s)
                      | ((bus.ren | bus.rd_release) & ~rd_valid_s);
    end

    // Pointer, occupancy and sticky error next-state.
    always_comb begin
        wr_ptr_nxt_s     = wr_ptr_r;
        rd_ptr_nxt_s     = rd_ptr_r;
        full_count_nxt_s = full_count_r;
        err_nxt_s        = err_r;
        if (commit_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (release_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // A simultaneous commit and release cancel out in the count.
        case ({commit_acc_s, release_acc_s})
            2'b10:   full_count_nxt_s = full_count_r + CNT_ONE;
            2'b01:   full_count_nxt_s = full_count_r - CNT_ONE;
            default: full_count_nxt_s = full_count_r;
        endcase
        if (proto_err_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            full_count_r  <= CNT_ZERO;
            rdata_valid_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            full_count_r  <= full_count_nxt_s;
            rdata_valid_r <= read_acc_s;
            err_r         <= err_nxt_s;
        end
    end

    assign ram_wadr_s = {wr_ptr_r, bus.wadr};
    assign ram_radr_s = {rd_ptr_r, bus.radr};

    ram_sync_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .wen   (write_acc_s),
        .wadr  (ram_wadr_s),
        .wdata (bus.wdata),
        .ren   (read_acc_s),
        .radr  (ram_radr_s),
        .rdata (ram_rdata_s)
    );

    assign bus.wr_ready    = wr_ready_s;
    assign bus.rd_valid    = rd_valid_s;
    assign bus.full_count  = full_count_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.rdata       = ram_rdata_s;
    assign bus.err         = err_r;
endmodule

// File: tb/tb_multi_bank_buffer.sv
// Self-checking bench for multi_bank_buffer: constant vector table, directed
// corner sequences and random traffic against a bank-queue reference model.
module tb_multi_bank_buffer;
    localparam int DW    = 64;
    localparam int AW    = 7;
    localparam int NB    = 4;
    localparam int SW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    multi_bank_buffer_if #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .BANK_SEL_WIDTH(SW)) bus();

    multi_bank_buffer #(
        .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .NUM_BANKS(NB), .BANK_SEL_WIDTH(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: bank contents, FIFO of full bank indices, write bank, sticky error.
    logic [DW-1:0] mem_m [NB][DEPTH];
    int            fq[$];
    int            wp;
    bit            err_m;

    typedef struct {
        logic          wen;
        logic [AW-1:0] wadr;
        logic [DW-1:0] wdata;
        logic          wr_commit;
        logic          ren;
        logic [AW-1:0] radr;
        logic          rd_release;
        logic [SW:0]   fc;
        logic          wr_ready;
        logic          rd_valid;
        logic          dv;
        logic [DW-1:0] rdata;
        logic          err;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wen = 1'b0; bus.wadr = '0; bus.wdata = '0; bus.wr_commit = 1'b0;
        bus.ren = 1'b0; bus.radr = '0; bus.rd_release = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string name, input int fc, input bit wr, input bit rv,
                                input bit dv, input bit er);
        check({name, "_full_count"}, 64'(bus.full_count), 64'(fc));
        check({name, "_wr_ready"}, 64'(bus.wr_ready), 64'(wr));
        check({name, "_rd_valid"}, 64'(bus.rd_valid), 64'(rv));
        check({name, "_rdata_valid"}, 64'(bus.rdata_valid), 64'(dv));
        check({name, "_err"}, 64'(bus.err), 64'(er));
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        fq.delete();
        wp    = 0;
        err_m = 1'b0;
    endtask

    // One clock of stimulus, predicted by the model and compared in full.
    task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic c, input logic r, input logic [AW-1:0] ra, input logic rel);
        bit wr_ok, rd_ok, aw, ac, ar, al;
        logic [DW-1:0] exp_rd;
        bus.wen = w; bus.wadr = wa; bus.wdata = wd; bus.wr_commit = c;
        bus.ren = r; bus.radr = ra; bus.rd_release = rel;
        wr_ok  = fq.size() < NB;
        rd_ok  = fq.size() != 0;
        aw     = w && wr_ok;
        ac     = c && wr_ok;
        ar     = r && rd_ok;
        al     = rel && rd_ok;
        exp_rd = '0;
        if ((w || c) && !wr_ok) err_m = 1'b1;
        if ((r || rel) && !rd_ok) err_m = 1'b1;
        if (ar) exp_rd = mem_m[fq[0]][ra];
        tick();
        idle_inputs();
        if (aw) mem_m[wp][wa] = wd;
        if (al) void'(fq.pop_front());
        if (ac) begin
            fq.push_back(wp);
            wp = (wp + 1) % NB;
        end
        check_status("model", fq.size(), fq.size() < NB, fq.size() != 0, ar, err_m);
        if (ar) check("model_rdata", bus.rdata, exp_rd);
    endtask

    task automatic fill_bank(input logic [DW-1:0] base);
        for (int a = 0; a < DEPTH; a++) cycle(1'b1, AW'(a), base + 64'(a), 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 7'd3, 64'hAAA, 1'b0, 1'b0, 7'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0,   1'b0};
        vecs[1] = '{1'b1, 7'd3, 64'hBBB, 1'b1, 1'b0, 7'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 64'h0,   1'b0};
        vecs[2] = '{1'b0, 7'd0, 64'h0,   1'b0, 1'b1, 7'd3, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 64'hBBB, 1'b0};
        vecs[3] = '{1'b1, 7'd3, 64'hCCC, 1'b1, 1'b0, 7'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 64'h0,   1'b0};
        vecs[4] = '{1'b0, 7'd0, 64'h0,   1'b0, 1'b1, 7'd3, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 64'hBBB, 1'b0};
        vecs[5] = '{1'b0, 7'd0, 64'h0,   1'b0, 1'b1, 7'd3, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 64'hCCC, 1'b0};
        vecs[6] = '{1'b0, 7'd0, 64'h0,   1'b0, 1'b0, 7'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0,   1'b0};
        vecs[7] = '{1'b0, 7'd0, 64'h0,   1'b0, 1'b1, 7'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0,   1'b1};
        vecs[8] = '{1'b0, 7'd0, 64'h0,   1'b0, 1'b0, 7'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0,   1'b1};

        // Constant vector table from reset.
        do_reset();
        check_status("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            bus.wen = vecs[i].wen; bus.wadr = vecs[i].wadr; bus.wdata = vecs[i].wdata;
            bus.wr_commit = vecs[i].wr_commit; bus.ren = vecs[i].ren; bus.radr = vecs[i].radr;
            bus.rd_release = vecs[i].rd_release;
            tick();
            idle_inputs();
            check_status($sformatf("vec%0d", i), int'(vecs[i].fc), vecs[i].wr_ready,
                         vecs[i].rd_valid, vecs[i].dv, vecs[i].err);
            if (vecs[i].dv) check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].rdata);
        end

        // Fill bank0, commit, random read.
        do_reset();
        fill_bank(64'h100);
        check_status("fill1", 1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd5, 1'b0);
        check("fill1_rdata", bus.rdata, 64'h105);
        check("fill1_dv", 64'(bus.rdata_valid), 64'd1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        check("fill1_dv_drop", 64'(bus.rdata_valid), 64'd0);

        // All four banks full; overflow write/commit rejected.
        do_reset();
        for (int b = 0; b < NB; b++) fill_bank(64'(b) << 8);
        check_status("full4", 4, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 7'd0, 64'hDEAD, 1'b1, 1'b0, '0, 1'b0);
        check_status("overflow", 4, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd0, 1'b0);
        check("overflow_bank0", bus.rdata, 64'h000);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd127, 1'b0);
        check("overflow_bank0_hi", bus.rdata, 64'h07F);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        check("full_commit_release", 64'(bus.full_count), 64'd3);

        // Commit+release together at full_count=2, then read+release together.
        do_reset();
        fill_bank(64'h000);
        fill_bank(64'h100);
        cycle(1'b1, 7'd0, 64'h2AA, 1'b1, 1'b0, '0, 1'b1);
        check("cr_full_count", 64'(bus.full_count), 64'd2);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd0, 1'b0);
        check("cr_read_bank1", bus.rdata, 64'h100);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd5, 1'b1);
        check("rr_old_bank", bus.rdata, 64'h105);
        check("rr_dv", 64'(bus.rdata_valid), 64'd1);
        check("rr_full_count", 64'(bus.full_count), 64'd1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd0, 1'b0);
        check("rr_next_bank", bus.rdata, 64'h2AA);

        // Pointer wrap after four commits and four releases.
        do_reset();
        for (int b = 0; b < NB; b++) cycle(1'b1, 7'd9, 64'(b) << 8, 1'b1, 1'b0, '0, 1'b0);
        for (int b = 0; b < NB; b++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 7'd9, 64'h5A5, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd9, 1'b0);
        check("wrap_rdata", bus.rdata, 64'h5A5);
        check("wrap_full_count", 64'(bus.full_count), 64'd1);

        // Underflow, then asynchronous reset with a read in flight.
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 7'd0, 1'b1);
        check_status("underflow", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("pre_arst_fc", 64'(bus.full_count), 64'd3);
        bus.ren = 1'b1;
        tick();
        idle_inputs();
        check("pre_arst_dv", 64'(bus.rdata_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("arst", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic: known contents first, then biased mostly-legal requests.
        do_reset();
        for (int b = 0; b < NB; b++) fill_bank(64'(b) << 8);
        for (int b = 0; b < NB; b++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            bit w, c, r, rel;
            int n;
            if (i == 1500) do_reset();
            n   = fq.size();
            w   = $urandom_range(0, 99) < 45;
            c   = $urandom_range(0, 99) < 12;
            r   = $urandom_range(0, 99) < 50;
            rel = $urandom_range(0, 99) < 10;
            if (n == NB && $urandom_range(0, 99) < 97) begin w = 1'b0; c = 1'b0; end
            if (n == 0  && $urandom_range(0, 99) < 97) begin r = 1'b0; rel = 1'b0; end
            cycle(w, AW'($urandom), {$urandom, $urandom}, c, r, AW'($urandom), rel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
